// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and datapath width.
// Used by the integer ALU and by the arbiter that time-shares it.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_t;

endpackage

// File: rtl/alu_int.sv
// Combinational integer ALU; zero latency, no flow control.
// Unknown opcodes produce result 0 (and therefore zero flag 1).
module alu_int
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = $signed(a_i) >>> b_i[4:0];
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority starts one past ptr.
// ptr moves to the granted index only when adv is strobed, otherwise holds.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] idx;

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int k = N; k >= 1; k--) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (adv) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one ALU among NUM_REQ requesters: accept -> issue reg -> response slot, result valid 2 cycles after accept.
// One outstanding op per requester; a held response blocks only its own requester.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_a,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_b,
    input  logic [NUM_REQ-1:0][3:0]           req_op,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag,
    output logic [NUM_REQ-1:0]                resp_valid,
    input  logic [NUM_REQ-1:0]                resp_ready,
    output logic [NUM_REQ-1:0][DATA_W-1:0]    resp_result,
    output logic [NUM_REQ-1:0]                resp_zero,
    output logic [NUM_REQ-1:0][TAG_W-1:0]     resp_tag,
    output logic [DATA_W-1:0]                 alu_a,
    output logic [DATA_W-1:0]                 alu_b,
    output logic [3:0]                        alu_op,
    input  logic [DATA_W-1:0]                 alu_result,
    input  logic                              alu_zero
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] grant, accept_vec, resp_hs, issue_oh;
    logic [IW-1:0]      grant_idx;
    logic               accept;

    logic                           iss_vld_q;
    logic [IW-1:0]                  iss_idx_q;
    logic [TAG_W-1:0]               iss_tag_q;
    logic [DATA_W-1:0]              alu_a_q, alu_b_q;
    alu_op_t                        alu_op_q;
    logic [NUM_REQ-1:0]             busy_q, busy_d;
    logic [NUM_REQ-1:0]             resp_vld_q, resp_vld_d;
    logic [NUM_REQ-1:0][DATA_W-1:0] resp_res_q;
    logic [NUM_REQ-1:0]             resp_zero_q;
    logic [NUM_REQ-1:0][TAG_W-1:0]  resp_tag_q;

    rr_arbiter #(.N(NUM_REQ), .PW(IW)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid & ~busy_q),
        .adv       (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready  = grant & ~busy_q;
    assign accept_vec = req_valid & req_ready;
    assign accept     = |accept_vec;
    assign resp_hs    = resp_vld_q & resp_ready;

    always_comb begin
        issue_oh = '0;
        if (iss_vld_q) issue_oh[iss_idx_q] = 1'b1;
    end

    // busy covers the whole accept-to-handshake window, so the slot is free at write time.
    assign busy_d     = (busy_q & ~resp_hs) | accept_vec;
    assign resp_vld_d = (resp_vld_q & ~resp_hs) | issue_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_vld_q   <= 1'b0;
            iss_idx_q   <= '0;
            iss_tag_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALU_ADD;
            busy_q      <= '0;
            resp_vld_q  <= '0;
            resp_res_q  <= '0;
            resp_zero_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            iss_vld_q  <= accept;
            busy_q     <= busy_d;
            resp_vld_q <= resp_vld_d;
            if (accept) begin
                iss_idx_q <= grant_idx;
                iss_tag_q <= req_tag[grant_idx];
                alu_a_q   <= req_a[grant_idx];
                alu_b_q   <= req_b[grant_idx];
                alu_op_q  <= alu_op_t'(req_op[grant_idx]);
            end
            if (iss_vld_q) begin
                resp_res_q[iss_idx_q]  <= alu_result;
                resp_zero_q[iss_idx_q] <= alu_zero;
                resp_tag_q[iss_idx_q]  <= iss_tag_q;
            end
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign resp_valid  = resp_vld_q;
    assign resp_result = resp_res_q;
    assign resp_zero   = resp_zero_q;
    assign resp_tag    = resp_tag_q;

endmodule
